// File: rtl/md5_msg_driver.sv
// md5_msg_driver: issues upstream candidate messages to a pancham MD5 core and emits one result record per candidate.
// Optional feature macro MD5_DRV_CMP_EN builds the target-digest comparator that drives res_match.
`timescale 1ns/1ps
module md5_msg_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned IDX_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cand_valid,
  output logic             cand_ready,
  input  logic [0:127]     cand_data,
  input  logic [0:7]       cand_width,
  input  logic [0:127]     target_digest,
  output logic [0:127]     md5_msg_in,
  output logic [0:7]       md5_msg_in_width,
  output logic             md5_msg_in_valid,
  input  logic             md5_ready,
  input  logic [0:127]     md5_msg_output,
  input  logic             md5_msg_out_valid,
  output logic             res_valid,
  output logic [0:127]     res_digest,
  output logic             res_match,
  output logic             res_timeout,
  output logic             res_bad_width,
  output logic [IDX_W-1:0] res_index,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DIG, REPORT} state_t;

  // Timer counts from 0, so the final WAIT_DIG cycle is the one holding TIMEOUT_CYCLES-1.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t       state;
  state_t       state_next;
  logic [0:127] msg_q;
  logic [0:7]   width_q;
  logic [15:0]  timer;
  logic         accept;
  logic         width_bad;
  logic         timer_done;
  logic         digest_hit;

  // cand_width[5:7] are the three least significant bits: non-zero means not a whole byte count.
  assign width_bad  = (cand_width > 8'd128) || (cand_width[5:7] != 3'b000);
  assign accept     = (state == IDLE) && cand_valid && md5_ready;
  assign timer_done = (timer == TIMER_LAST);
  assign digest_hit = (state == WAIT_DIG) && md5_msg_out_valid;

  assign md5_msg_in       = msg_q;
  assign md5_msg_in_width = width_q;
  assign md5_msg_in_valid = (state == ISSUE);
  assign busy             = (state != IDLE);

  always_comb begin
    state_next = state;
    cand_ready = 1'b0;
    case (state)
      IDLE: begin
        cand_ready = md5_ready;
        if (accept) begin
          state_next = width_bad ? REPORT : ISSUE;
        end
      end
      ISSUE:    state_next = WAIT_DIG;
      WAIT_DIG: if (md5_msg_out_valid || timer_done) state_next = REPORT;
      REPORT:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_q   <= '0;
      width_q <= '0;
    end else if (accept) begin
      msg_q   <= cand_data;
      width_q <= cand_width;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (state == ISSUE) begin
      timer <= '0;
    end else if (state == WAIT_DIG) begin
      timer <= timer + 16'd1;
    end
  end

  // A digest arriving in the last WAIT_DIG cycle takes priority over the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid     <= 1'b0;
      res_digest    <= '0;
      res_timeout   <= 1'b0;
      res_bad_width <= 1'b0;
      res_index     <= '0;
    end else begin
      res_valid <= 1'b0;
      if (accept && width_bad) begin
        res_valid     <= 1'b1;
        res_digest    <= '0;
        res_timeout   <= 1'b0;
        res_bad_width <= 1'b1;
      end else if (digest_hit) begin
        res_valid     <= 1'b1;
        res_digest    <= md5_msg_output;
        res_timeout   <= 1'b0;
        res_bad_width <= 1'b0;
      end else if ((state == WAIT_DIG) && timer_done) begin
        res_valid     <= 1'b1;
        res_digest    <= '0;
        res_timeout   <= 1'b1;
        res_bad_width <= 1'b0;
      end
      if (state == REPORT) begin
        res_index <= res_index + IDX_W'(1);
      end
    end
  end

`ifdef MD5_DRV_CMP_EN
  logic [0:127] target_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q <= '0;
    end else if (accept) begin
      target_q <= target_digest;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_match <= 1'b0;
    end else if (accept && width_bad) begin
      res_match <= 1'b0;
    end else if (digest_hit) begin
      res_match <= (md5_msg_output == target_q);
    end else if ((state == WAIT_DIG) && timer_done) begin
      res_match <= 1'b0;
    end
  end
`else
  logic unused_target;
  assign unused_target = ^target_digest;
  assign res_match     = 1'b0;
`endif

endmodule

// File: tb/tb_md5_msg_driver.sv
// Scoreboard bench for md5_msg_driver: stimulus queues expected issues/results, a negedge monitor pops and compares.
// A small behavioural stand-in for the pancham core answers with a configurable latency.
`timescale 1ns/1ps
module tb_md5_msg_driver;

  localparam int TMO   = 10;
  localparam int IDX_W = 2;
`ifdef MD5_DRV_CMP_EN
  localparam bit MATCH_EN = 1'b1;
`else
  localparam bit MATCH_EN = 1'b0;
`endif
  localparam int K_DIGEST  = 0;
  localparam int K_TIMEOUT = 1;
  localparam int K_BAD     = 2;

  localparam logic [0:127] DIG_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [0:127] DIG_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;

  typedef struct {
    logic [0:127]     digest;
    logic             match;
    logic             timeout;
    logic             bad;
    logic [IDX_W-1:0] index;
    int               kind;
  } res_t;

  typedef struct {
    logic [0:127] msg;
    logic [0:7]   width;
  } iss_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             cand_valid;
  logic             cand_ready;
  logic [0:127]     cand_data;
  logic [0:7]       cand_width;
  logic [0:127]     target_digest;
  logic [0:127]     md5_msg_in;
  logic [0:7]       md5_msg_in_width;
  logic             md5_msg_in_valid;
  logic             md5_ready;
  logic [0:127]     md5_msg_output;
  logic             md5_msg_out_valid;
  logic             res_valid;
  logic [0:127]     res_digest;
  logic             res_match;
  logic             res_timeout;
  logic             res_bad_width;
  logic [IDX_W-1:0] res_index;
  logic             busy;

  int               cyc = 0;
  int               checks = 0;
  int               errors = 0;
  int               issue_cyc = -100;
  int               accept_cyc = -100;
  int               dig_cyc = -100;
  int               core_lat = 3;
  int               ready_mode = 0;
  logic             tog = 1'b1;
  logic             prev_iss;
  logic [0:127]     core_d;
  logic [IDX_W-1:0] exp_idx = '0;
  res_t             exp_res[$];
  iss_t             exp_iss[$];

  md5_msg_driver #(.TIMEOUT_CYCLES(TMO), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset),
    .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_data(cand_data),
    .cand_width(cand_width), .target_digest(target_digest),
    .md5_msg_in(md5_msg_in), .md5_msg_in_width(md5_msg_in_width),
    .md5_msg_in_valid(md5_msg_in_valid), .md5_ready(md5_ready),
    .md5_msg_output(md5_msg_output), .md5_msg_out_valid(md5_msg_out_valid),
    .res_valid(res_valid), .res_digest(res_digest), .res_match(res_match),
    .res_timeout(res_timeout), .res_bad_width(res_bad_width),
    .res_index(res_index), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // md5_ready: 0 = held low, 1 = held high, 2 = low one cycle in four.
  assign md5_ready = (ready_mode == 1) || ((ready_mode == 2) && tog);

  initial forever begin
    @(posedge clk);
    #1;
    tog = ((cyc % 4) != 3);
  end

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
    end
  endtask

  // Stand-in digest for messages whose real MD5 is not tabulated in the core model.
  function automatic logic [0:127] fake_digest(input logic [0:127] m, input logic [0:7] w);
    return ~m ^ {16{w}};
  endfunction

  function automatic logic [0:127] core_digest(input logic [0:127] m, input logic [0:7] w);
    if ((w == 8'd24) && (m == {"abc", 104'd0})) return DIG_ABC;
    if (w == 8'd0) return DIG_EMPTY;
    return fake_digest(m, w);
  endfunction

  // Core stand-in: answers core_lat cycles after the request cycle; core_lat 0 means never.
  initial begin
    md5_msg_out_valid = 1'b0;
    md5_msg_output    = '0;
    forever begin
      @(negedge clk);
      if ((md5_msg_in_valid === 1'b1) && (core_lat > 0)) begin
        core_d = core_digest(md5_msg_in, md5_msg_in_width);
        repeat (core_lat) @(posedge clk);
        #1;
        md5_msg_output    = core_d;
        md5_msg_out_valid = 1'b1;
        dig_cyc           = cyc;
        @(posedge clk);
        #1;
        md5_msg_out_valid = 1'b0;
        md5_msg_output    = '0;
      end
    end
  end

  // Monitor: compares every issue pulse and result strobe against the queued expectations.
  initial begin
    iss_t s;
    res_t r;
    prev_iss = 1'b0;
    forever begin
      @(negedge clk);
      if (md5_ready !== 1'b1) check_output("cand_ready_gated", 128'(cand_ready), 128'(0));
      if ((cand_valid === 1'b1) && (cand_ready === 1'b1)) accept_cyc = cyc;
      if (md5_msg_in_valid === 1'b1) begin
        check_output("issue_single_pulse", 128'(prev_iss), 128'(0));
        if (exp_iss.size() == 0) begin
          check_output("unexpected_issue", 128'(1), 128'(0));
        end else begin
          s = exp_iss.pop_front();
          check_output("issue_msg", 128'(md5_msg_in), 128'(s.msg));
          check_output("issue_width", 128'(md5_msg_in_width), 128'(s.width));
          check_output("issue_latency", 128'(cyc), 128'(accept_cyc + 1));
        end
        issue_cyc = cyc;
      end
      prev_iss = md5_msg_in_valid;
      if (res_valid === 1'b1) begin
        if (exp_res.size() == 0) begin
          check_output("unexpected_result", 128'(1), 128'(0));
        end else begin
          r = exp_res.pop_front();
          check_output("res_digest", 128'(res_digest), 128'(r.digest));
          check_output("res_match", 128'(res_match), 128'(r.match));
          check_output("res_timeout", 128'(res_timeout), 128'(r.timeout));
          check_output("res_bad_width", 128'(res_bad_width), 128'(r.bad));
          check_output("res_index", 128'(res_index), 128'(r.index));
          if (r.kind == K_DIGEST)
            check_output("digest_latency", 128'(cyc), 128'(dig_cyc + 1));
          else if (r.kind == K_TIMEOUT)
            check_output("timeout_latency", 128'(cyc), 128'(issue_cyc + TMO + 1));
          else
            check_output("bad_width_latency", 128'(cyc), 128'(accept_cyc + 1));
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the candidate.
  task automatic apply_stimulus(input logic [0:127] data, input logic [0:7] width, input logic [0:127] target,
                                input int kind, input logic [0:127] exp_digest, input bit expect_result);
    res_t r;
    iss_t s;
    int   waited;
    if (kind != K_BAD) begin
      s.msg   = data;
      s.width = width;
      exp_iss.push_back(s);
    end
    if (expect_result) begin
      r.digest  = (kind == K_DIGEST) ? exp_digest : '0;
      r.match   = MATCH_EN && (kind == K_DIGEST) && (exp_digest == target);
      r.timeout = (kind == K_TIMEOUT);
      r.bad     = (kind == K_BAD);
      r.index   = exp_idx;
      r.kind    = kind;
      exp_idx++;
      exp_res.push_back(r);
    end
    cand_data     = data;
    cand_width    = width;
    target_digest = target;
    cand_valid    = 1'b1;
    waited        = 0;
    do begin
      @(negedge clk);
      waited++;
    end while ((cand_ready !== 1'b1) && (waited < 200));
    if (cand_ready !== 1'b1) check_output("accept_wait", 128'(cand_ready), 128'(1));
    @(posedge clk);
    #1;
    cand_valid    = 1'b0;
    cand_data     = '0;
    cand_width    = '0;
    target_digest = '0;
  endtask

  task automatic wait_idle();
    int waited = 0;
    while (((exp_res.size() != 0) || (exp_iss.size() != 0) || (busy !== 1'b0)) && (waited < 300)) begin
      @(negedge clk);
      waited++;
    end
    check_output("drain_pending", 128'(exp_res.size() + exp_iss.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    cand_valid    = 1'b0;
    cand_data     = '0;
    cand_width    = '0;
    target_digest = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_cand_ready", 128'(cand_ready), 128'(0));
    check_output("rst_msg_in_valid", 128'(md5_msg_in_valid), 128'(0));
    check_output("rst_msg_in", 128'(md5_msg_in), 128'(0));
    check_output("rst_res_valid", 128'(res_valid), 128'(0));
    check_output("rst_res_digest", 128'(res_digest), 128'(0));
    check_output("rst_res_flags", 128'({res_match, res_timeout, res_bad_width}), 128'(0));
    check_output("rst_res_index", 128'(res_index), 128'(0));
    check_output("rst_busy", 128'(busy), 128'(0));
    reset      = 1'b0;
    ready_mode = 1;
    @(posedge clk);
    #1;

    $display("[TB] abc and empty message");
    core_lat = 3;
    apply_stimulus({"abc", 104'd0}, 8'd24, DIG_ABC, K_DIGEST, DIG_ABC, 1'b1);
    wait_idle();
    apply_stimulus('0, 8'd0, '0, K_DIGEST, DIG_EMPTY, 1'b1);
    wait_idle();

    $display("[TB] bad widths 20 and 136");
    apply_stimulus({"abc", 104'd0}, 8'd20, 128'h1, K_BAD, '0, 1'b1);
    apply_stimulus({"abc", 104'd0}, 8'd136, 128'h1, K_BAD, '0, 1'b1);
    wait_idle();

    $display("[TB] digest in final wait cycle, then timeout");
    core_lat = TMO;
    apply_stimulus({"xy", 112'd0}, 8'd16, 128'h5, K_DIGEST, fake_digest({"xy", 112'd0}, 8'd16), 1'b1);
    wait_idle();
    core_lat = 0;
    apply_stimulus({"abc", 104'd0}, 8'd24, 128'h7, K_TIMEOUT, '0, 1'b1);
    wait_idle();

    $display("[TB] reset during WAIT_DIG with late digest");
    core_lat = 8;
    apply_stimulus({"abc", 104'd0}, 8'd24, DIG_ABC, K_DIGEST, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_output("pre_reset_busy", 128'(busy), 128'(1));
    reset = 1'b1;
    #1;
    check_output("async_rst_msg_in_valid", 128'(md5_msg_in_valid), 128'(0));
    check_output("async_rst_busy", 128'(busy), 128'(0));
    check_output("async_rst_res_index", 128'(res_index), 128'(0));
    @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_idx = '0;
    repeat (8) @(posedge clk);
    #1;
    check_output("post_rst_busy", 128'(busy), 128'(0));
    check_output("post_rst_res_valid", 128'(res_valid), 128'(0));
    check_output("post_rst_res_digest", 128'(res_digest), 128'(0));
    check_output("post_rst_res_index", 128'(res_index), 128'(0));

    $display("[TB] back-to-back with md5_ready toggling");
    core_lat   = 2;
    ready_mode = 2;
    apply_stimulus({"lex", 104'd0}, 8'd24, '0, K_DIGEST, fake_digest({"lex", 104'd0}, 8'd24), 1'b1);
    apply_stimulus({"akha", 96'd0}, 8'd32, '0, K_DIGEST, fake_digest({"akha", 96'd0}, 8'd32), 1'b1);
    apply_stimulus({"vader", 88'd0}, 8'd40, fake_digest({"vader", 88'd0}, 8'd40), K_DIGEST,
                   fake_digest({"vader", 88'd0}, 8'd40), 1'b1);
    apply_stimulus({"jackson", 72'd0}, 8'd56, '0, K_DIGEST, fake_digest({"jackson", 72'd0}, 8'd56), 1'b1);
    wait_idle();
    ready_mode = 1;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/md5_msg_driver.md
# md5_msg_driver

Initiator-side controller for the pancham MD5 core. It accepts candidate messages from an upstream valid/ready stream and issues each one to the core's `msg_in` handshake. It then waits for `msg_out_valid`, captures the digest and optionally compares it against a target. Each candidate produces exactly one result record, covering a digest, a timeout or a bad width. It sits between a candidate generator (dictionary/brute-force source) and the pancham instance.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles allowed in WAIT_DIG before declaring timeout (1..65535).
- `IDX_W`, default 16: width of the candidate index counter.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `cand_valid`  in  1  upstream candidate present.
- `cand_ready`  out  1  driver can accept a candidate.
- `cand_data`  in  [0:127]  message bytes, left-aligned (byte 0 in bits 0:7).
- `cand_width`  in  [0:7]  message length in bits.
- `target_digest`  in  [0:127]  expected digest, sampled at candidate acceptance.
- `md5_msg_in`  out  [0:127]  to core `msg_in`.
- `md5_msg_in_width`  out  [0:7]  to core `msg_in_width`.
- `md5_msg_in_valid`  out  1  to core `msg_in_valid`.
- `md5_ready`  in  1  from core `ready`.
- `md5_msg_output`  in  [0:127]  from core `msg_output`.
- `md5_msg_out_valid`  in  1  from core `msg_out_valid`.
- `res_valid`  out  1  one-cycle result strobe.
- `res_digest`  out  [0:127]  captured digest (0 on timeout or bad width).
- `res_match`  out  1  digest equals latched target.
- `res_timeout`  out  1  core did not answer in time.
- `res_bad_width`  out  1  candidate rejected and not issued.
- `res_index`  out  [IDX_W-1:0]  sequence number of this result.
- `busy`  out  1  FSM not in IDLE.

## Operation
- FSM: IDLE, ISSUE, WAIT_DIG, REPORT.
- IDLE:
  - `cand_ready = md5_ready`.
  - On `cand_valid && cand_ready`, latch data, width and target.
  - If width > 128 or width[5:7] != 0 (not a byte multiple), go to REPORT with bad_width. Otherwise go to ISSUE.
- ISSUE: `md5_msg_in_valid` = 1 for exactly one cycle with the latched data and width; go to WAIT_DIG and clear the timer.
- WAIT_DIG:
  - Timer increments each cycle.
  - On `md5_msg_out_valid`, capture `md5_msg_output`, compute the match and go to REPORT.
  - When the timer reaches `TIMEOUT_CYCLES`, set timeout and go to REPORT.
- REPORT: `res_*` are registered outputs, valid while `res_valid` = 1 (one cycle). `res_index` increments after the report and wraps from 2^IDX_W-1 to 0. Then return to IDLE.
- `md5_msg_out_valid` outside WAIT_DIG is ignored.
- Width 0 is legal and is issued.
- `cand_ready` is 0 in every state except IDLE.

## Timing
- Reset values:
  - all outputs 0;
  - `res_index` 0;
  - FSM in IDLE.
- Reset mid-operation drops `md5_msg_in_valid` immediately (async); any in-flight digest is discarded.
- Accept at edge T, then `md5_msg_in_valid` is high in cycle T+1 only.
- Digest valid in cycle D, then `res_valid` is high in cycle D+1.
- Bad width accepted at T gives `res_valid` in cycle T+1, with no core activity.
- Timeout: `res_valid` asserts `TIMEOUT_CYCLES`+1 cycles after ISSUE.
- Digest and timeout in the same cycle: the digest wins and `res_timeout` = 0.
- Back-to-back: the next candidate can be accepted in the cycle after REPORT, provided `md5_ready` = 1.

## Configuration
- `MD5_DRV_CMP_EN` defined: the 128-bit comparator is built, `target_digest` is latched and `res_match` is driven.
- Not defined: no comparator or target register, `res_match` tied 0, `target_digest` unused.

## Test plan
- "abc", width 24, target 900150983cd24fb0d6963f7d28e17f72 gives:
  - one `md5_msg_in_valid` pulse;
  - `res_digest` equal to the target;
  - `res_match` = 1 (with `MD5_DRV_CMP_EN`);
  - `res_index` = 0.
- Empty message, width 0, target all-zero gives `res_digest` d41d8cd98f00b204e9800998ecf8427e, `res_match` = 0, `res_index` = 1.
- Width 20, then width 136, gives two results with `res_bad_width` = 1 and `md5_msg_in_valid` never asserted.
- Core model never asserts `md5_msg_out_valid`, with `TIMEOUT_CYCLES` = 10, gives `res_timeout` = 1 exactly 11 cycles after ISSUE and `res_digest` = 0.
- Four back-to-back candidates ("lex", "akha", "vader", "jackson") with `md5_ready` toggling:
  - `cand_ready` never high while `md5_ready` = 0;
  - `res_index` values 0..3 in order.
- `reset` pulsed during WAIT_DIG, then the late `md5_msg_out_valid` arrives: no `res_valid`, outputs at reset values, `busy` = 0.
